// File: rtl/i2s_unit_if.sv
// rtl/i2s_unit_if.sv - upstream sample handshake and I2S bus bundle for i2s_unit
//
// play_in    level, 1 = play, 0 = stop after the current frame
// tick_in    one-cycle pulse, audio0_in/audio1_in valid
// audio0_in  24-bit left sample, two's complement
// audio1_in  24-bit right sample, two's complement
// req_out    one-cycle pulse requesting the next sample
// sck_out    I2S serial clock (clk/8)
// ws_out     I2S word select, 0 = left, 1 = right
// sdo_out    I2S serial data, MSB first
//
// master: upstream / bench side; slave: i2s_unit side.
interface i2s_unit_if;
  logic        play_in;
  logic        tick_in;
  logic [23:0] audio0_in;
  logic [23:0] audio1_in;
  logic        req_out;
  logic        sck_out;
  logic        ws_out;
  logic        sdo_out;

  modport master (
    output play_in, tick_in, audio0_in, audio1_in,
    input  req_out, sck_out, ws_out, sdo_out
  );

  modport slave (
    input  play_in, tick_in, audio0_in, audio1_in,
    output req_out, sck_out, ws_out, sdo_out
  );
endinterface

// File: rtl/i2s_unit.sv
// rtl/i2s_unit.sv - audioport output stage, serialises 24-bit stereo samples onto I2S
//
// clk    mclk-domain clock
// rst_n  asynchronous active-low reset
// bus    i2s_unit_if.slave: play_in, tick_in, audio0_in, audio1_in in;
//        req_out, sck_out, ws_out, sdo_out out (all outputs registered)
//
// One frame is 384 clk cycles = 48 sck periods of 8 cycles. Bit slot ctr[8:3]
// 0..23 carries left bits 23..0, slots 24..47 carry right bits 23..0.
module i2s_unit (
  input  logic      clk,
  input  logic      rst_n,
  i2s_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PLAY, STOPPING} state_t;

  localparam logic [8:0] CTR_LAST  = 9'd383;
  localparam logic [8:0] WS_FIRST  = 9'd184;
  localparam logic [8:0] WS_LAST   = 9'd375;

  state_t      state, state_nxt;
  logic [8:0]  ctr, ctr_nxt;
  logic [47:0] sh, sh_nxt;
  logic [47:0] smp, smp_nxt;
  logic        full, full_nxt;
  logic        frame_end;
  logic        load;
  logic        active_nxt;

  logic        req_q, sck_q, ws_q, sdo_q;

  assign bus.req_out = req_q;
  assign bus.sck_out = sck_q;
  assign bus.ws_out  = ws_q;
  assign bus.sdo_out = sdo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ctr   <= '0;
      sh    <= '0;
      smp   <= '0;
      full  <= 1'b0;
      req_q <= 1'b0;
      sck_q <= 1'b0;
      ws_q  <= 1'b0;
      sdo_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ctr   <= ctr_nxt;
      sh    <= sh_nxt;
      smp   <= smp_nxt;
      full  <= full_nxt;
      // Outputs are computed from next-state values so they line up with
      // state/ctr/sh in the same cycle while still coming straight off flops.
      req_q <= (state_nxt == PLAY) && (ctr_nxt == 9'd0);
      sck_q <= active_nxt && ctr_nxt[2];
      ws_q  <= active_nxt && (ctr_nxt >= WS_FIRST) && (ctr_nxt <= WS_LAST);
      sdo_q <= active_nxt && sh_nxt[47];
    end
  end

  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    sh_nxt    = sh;
    smp_nxt   = smp;
    full_nxt  = full;
    load      = 1'b0;
    frame_end = (ctr == CTR_LAST);

    case (state)
      IDLE: begin
        if (bus.play_in) begin
          state_nxt = PLAY;
          load      = 1'b1;
        end
      end
      PLAY: begin
        ctr_nxt = frame_end ? 9'd0 : ctr + 9'd1;
        load    = frame_end;
        if (!bus.play_in) begin
          state_nxt = STOPPING;
        end
      end
      STOPPING: begin
        ctr_nxt = frame_end ? 9'd0 : ctr + 9'd1;
        if (frame_end) begin
          state_nxt = IDLE;
        end else if (bus.play_in) begin
          state_nxt = PLAY;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Frame-start load wins over the slot shift that would otherwise happen
    // at ctr=383; an empty buffer sends silence.
    if (load) begin
      sh_nxt   = full ? smp : 48'd0;
      full_nxt = 1'b0;
    end else if ((state != IDLE) && (ctr[2:0] == 3'd7)) begin
      sh_nxt = {sh[46:0], 1'b0};
    end

    // A tick on the load edge is applied after the load, so the shift
    // register takes the old contents and the buffer keeps the new pair.
    if ((state != IDLE) && bus.tick_in) begin
      smp_nxt  = {bus.audio0_in, bus.audio1_in};
      full_nxt = 1'b1;
    end

    if (state_nxt == IDLE) begin
      ctr_nxt  = '0;
      sh_nxt   = '0;
      smp_nxt  = '0;
      full_nxt = 1'b0;
    end

    active_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_i2s_unit.sv
// tb/tb_i2s_unit.sv - scoreboard bench for i2s_unit, directed frames checked by a bus monitor
`timescale 1ns/1ps
module tb_i2s_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2s_unit_if bus ();

  i2s_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks    = 0;
  int n_fail      = 0;
  int frames_done = 0;
  int cur         = 0;
  logic [47:0] exp_q[$];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.req_out, bus.sck_out, bus.ws_out, bus.sdo_out};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic run_to(input int c);
    while (cur < c) step();
  endtask

  task automatic frame_start(input string name);
    run_to(384);
    chk(name, {47'd0, bus.req_out}, 48'd1);
    cur = 0;
  endtask

  task automatic tick_at(input int c, input logic [23:0] l, input logic [23:0] r);
    run_to(c);
    bus.tick_in   = 1'b1;
    bus.audio0_in = l;
    bus.audio1_in = r;
    step();
    bus.tick_in   = 1'b0;
  endtask

  // Monitor: frames are delimited by req_out; sdo is captured at each sck
  // rising edge (position 4 of each 8-cycle slot) and compared with the
  // scoreboard at the last cycle of the frame.
  initial begin : monitor
    bit          in_frame  = 0;
    bit          have_prev = 0;
    int          pos       = 0;
    int          cyc       = 0;
    int          ws_err    = 0;
    int          sck_err   = 0;
    logic [47:0] cap       = '0;
    logic [47:0] expv;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame  = 0;
        have_prev = 0;
      end else begin
        cyc++;
        if (bus.req_out) begin
          if (in_frame) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_early: req_out at frame position %0d, required 384", pos);
          end
          if (have_prev) chk("req_period", cyc, 384);
          have_prev = 1;
          cyc       = 0;
          in_frame  = 1;
          pos       = 0;
          cap       = '0;
          ws_err    = 0;
          sck_err   = 0;
        end else if (in_frame) begin
          pos++;
        end else begin
          have_prev = 0;
        end
        if (in_frame) begin
          if (pos % 8 == 4) cap = {cap[46:0], bus.sdo_out};
          if (bus.sck_out !== ((pos % 8) >= 4)) sck_err++;
          if (bus.ws_out !== (pos >= 184 && pos <= 375)) ws_err++;
          if (pos == 383) begin
            in_frame = 0;
            frames_done++;
            chk("ws_pattern", ws_err, 0);
            chk("sck_pattern", sck_err, 0);
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL frame_data: got 0x%0h, no expected frame queued", cap);
            end else begin
              expv = exp_q.pop_front();
              chk("frame_data", cap, expv);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int nz;
    rst_n         = 1'b0;
    bus.play_in   = 1'b0;
    bus.tick_in   = 1'b0;
    bus.audio0_in = '0;
    bus.audio1_in = '0;
    repeat (3) step();
    chk("reset_outs", {44'd0, outs()}, 48'd0);
    rst_n = 1'b1;

    // Tick in IDLE must be ignored: frame A still sends silence.
    step();
    tick_at(cur + 2, 24'h999999, 24'h999999);
    step();
    chk("idle_outs", {44'd0, outs()}, 48'd0);

    // Frame A: first frame after start is always silence.
    exp_q.push_back(48'h0);
    bus.play_in = 1'b1;
    step();
    chk("start_req", {47'd0, bus.req_out}, 48'd1);
    cur = 0;
    tick_at(20, 24'hABCDEF, 24'h123456);
    exp_q.push_back({24'hABCDEF, 24'h123456});

    // Frame B: data frame, no tick -> frame C underruns.
    frame_start("req_frame_b");
    exp_q.push_back(48'h0);

    // Frame C: pair one early, pair two exactly on the load edge.
    frame_start("req_frame_c");
    tick_at(20, 24'h000001, 24'h800000);
    exp_q.push_back({24'h000001, 24'h800000});
    tick_at(383, 24'h7FFFFF, 24'hFFFFFF);
    exp_q.push_back({24'h7FFFFF, 24'hFFFFFF});

    // Frame D: no tick; buffer already holds the coincident pair for E.
    frame_start("req_frame_d");

    // Frame E: two ticks, newest wins in F.
    frame_start("req_frame_e");
    tick_at(20, 24'h111111, 24'h222222);
    tick_at(60, 24'h333333, 24'h444444);
    exp_q.push_back({24'h333333, 24'h444444});

    // Frame F: stop at 100, resume at 200 -> PLAY continues uninterrupted.
    frame_start("req_frame_f");
    tick_at(20, 24'hABCDEF, 24'h123456);
    exp_q.push_back({24'hABCDEF, 24'h123456});
    run_to(100);
    bus.play_in = 1'b0;
    run_to(200);
    bus.play_in = 1'b1;

    // Frame G: stop at 100; the tick must be discarded on entry to IDLE.
    frame_start("req_after_resume");
    tick_at(20, 24'h555555, 24'h666666);
    run_to(100);
    bus.play_in = 1'b0;
    nz = 0;
    while (cur < 384) begin
      step();
      if (cur < 384 && bus.req_out) nz++;
    end
    chk("stopping_req_count", nz, 0);
    chk("outs_after_stop", {44'd0, outs()}, 48'd0);
    nz = 0;
    repeat (500) begin
      step();
      if (outs() != 4'd0) nz++;
    end
    chk("idle_after_stop", nz, 0);

    // Frame H: restart; buffer was cleared so silence again.
    exp_q.push_back(48'h0);
    bus.play_in = 1'b1;
    step();
    chk("restart_req", {47'd0, bus.req_out}, 48'd1);
    cur = 0;
    tick_at(20, 24'hABCDEF, 24'h123456);
    exp_q.push_back({24'hABCDEF, 24'h123456});

    // Frame I: asynchronous reset mid-slot while sck and sdo are high.
    frame_start("req_frame_i");
    run_to(5);
    chk("pre_reset_sdo_sck", {46'd0, bus.sck_out, bus.sdo_out}, 48'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {44'd0, outs()}, 48'd0);
    bus.play_in = 1'b0;
    exp_q.delete();
    repeat (3) step();
    chk("held_reset_outs", {44'd0, outs()}, 48'd0);
    rst_n = 1'b1;
    nz = 0;
    repeat (50) begin
      step();
      if (outs() != 4'd0) nz++;
    end
    chk("idle_after_reset", nz, 0);
    chk("frames_checked", frames_done, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
